// File: rtl/mul_limb_scheduler_pkg.sv
// Shared widths, FSM state type and limb-select helper for the limb-sequenced
// 1024x1024 multiplier scheduler.
package mul_sched_pkg;

   localparam int LIMB_W = 256;
   localparam int LIMBS  = 4;
   localparam int OP_W   = LIMB_W * LIMBS;
   localparam int RES_W  = 2 * OP_W;
   localparam int PROD_W = 2 * LIMB_W;
   localparam int IDX_W  = $clog2(LIMBS);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_ACC    = 3'd3,
      ST_FINISH = 3'd4
   } sched_state_e;

   function automatic logic [LIMB_W-1:0] limb_sel(input logic [OP_W-1:0]  op,
                                                  input logic [IDX_W-1:0] idx);
      return op[32'(idx) * LIMB_W +: LIMB_W];
   endfunction

endpackage

// File: rtl/mul_limb_scheduler_if.sv
// Control-side request/response and multiplier-side issue/return signals of
// the scheduler; the scheduler takes the slave view.
interface mul_limb_scheduler_if;
   import mul_sched_pkg::*;

   logic              start;
   logic              abort;
   logic [OP_W-1:0]   op_a;
   logic [OP_W-1:0]   op_b;
   logic              busy;
   logic              done;
   logic              err;
   logic [RES_W-1:0]  result;
   logic              mul_start;
   logic [LIMB_W-1:0] mul_a;
   logic [LIMB_W-1:0] mul_b;
   logic              mul_done;
   logic [PROD_W-1:0] mul_p;

   modport slave (
      input  start, abort, op_a, op_b, mul_done, mul_p,
      output busy, done, err, result, mul_start, mul_a, mul_b
   );

   modport master (
      output start, abort, op_a, op_b, mul_done, mul_p,
      input  busy, done, err, result, mul_start, mul_a, mul_b
   );

endinterface

// File: rtl/mul_limb_scheduler_limb_shift_acc.sv
// 2048-bit accumulator adding a 512-bit partial product at limb offset
// shift_i; the wide adder lives here on its own for timing closure.
module limb_shift_acc
   import mul_sched_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              add_i,
   input  logic [IDX_W:0]    shift_i,
   input  logic [PROD_W-1:0] addend_i,
   output logic [RES_W-1:0]  sum_o
);

   logic [RES_W-1:0] acc_q;
   logic [RES_W-1:0] addend_sh_s;

   assign addend_sh_s = RES_W'(addend_i) << (32'(shift_i) * LIMB_W);
   assign sum_o       = acc_q + addend_sh_s;

   // Accumulator register: clear on a new operation, add when enabled.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q <= '0;
      end else if (clr_i) begin
         acc_q <= '0;
      end else if (add_i) begin
         acc_q <= sum_o;
      end else begin
         acc_q <= acc_q;
      end
   end

endmodule

// File: rtl/mul_limb_scheduler.sv
// Sequences the 16 limb-pair products of a 1024x1024 multiply through one
// shared 256x256 multiplier and accumulates them into a 2048-bit result.
module mul_limb_scheduler
   import mul_sched_pkg::*;
#(
   parameter int TIMEOUT = 1023
) (
   input logic                 clk_i,
   input logic                 rst_i,
   mul_limb_scheduler_if.slave bus
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LIMBS - 1);

   sched_state_e      state_q;
   logic [OP_W-1:0]   a_q;
   logic [OP_W-1:0]   b_q;
   logic [IDX_W-1:0]  i_q;
   logic [IDX_W-1:0]  j_q;
   logic [IDX_W-1:0]  i_d;
   logic [IDX_W-1:0]  j_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic [PROD_W-1:0] prod_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;
   logic              mul_start_q;
   logic [RES_W-1:0]  result_q;
   logic [LIMB_W-1:0] mul_a_q;
   logic [LIMB_W-1:0] mul_b_q;

   logic              last_pair_s;
   logic              acc_clr_s;
   logic              acc_add_s;
   logic [IDX_W:0]    shift_s;
   logic [RES_W-1:0]  acc_sum_s;

   // j is the inner index, i the outer one: a0b0, a0b1, ... a3b3.
   assign last_pair_s = (i_q == IDX_LAST) && (j_q == IDX_LAST);
   assign j_d         = (j_q == IDX_LAST) ? IDX_W'(0) : j_q + IDX_W'(1);
   assign i_d         = (j_q == IDX_LAST) ? i_q + IDX_W'(1) : i_q;
   assign cnt_d       = cnt_q + CNT_W'(1);
   assign shift_s     = {1'b0, i_q} + {1'b0, j_q};
   assign acc_clr_s   = (state_q == ST_IDLE) && bus.start;
   assign acc_add_s   = (state_q == ST_ACC) && !bus.abort;

   limb_shift_acc u_acc (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (acc_clr_s),
      .add_i    (acc_add_s),
      .shift_i  (shift_s),
      .addend_i (prod_q),
      .sum_o    (acc_sum_s)
   );

   // Scheduler FSM with all outputs registered.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         i_q         <= '0;
         j_q         <= '0;
         cnt_q       <= '0;
         prod_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         mul_start_q <= 1'b0;
         result_q    <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
      end else begin
         mul_start_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         // Abort outranks everything outside IDLE, including a returning mul_done.
         if (bus.abort && (state_q != ST_IDLE)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (bus.start) begin
                     a_q         <= bus.op_a;
                     b_q         <= bus.op_b;
                     i_q         <= IDX_W'(0);
                     j_q         <= IDX_W'(0);
                     mul_a_q     <= limb_sel(bus.op_a, IDX_W'(0));
                     mul_b_q     <= limb_sel(bus.op_b, IDX_W'(0));
                     mul_start_q <= 1'b1;
                     busy_q      <= 1'b1;
                     state_q     <= ST_ISSUE;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
               ST_ISSUE: begin
                  cnt_q   <= CNT_W'(0);
                  state_q <= ST_WAIT;
               end
               ST_WAIT: begin
                  if (bus.mul_done) begin
                     prod_q  <= bus.mul_p;
                     state_q <= ST_ACC;
                  end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                     err_q   <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
               ST_ACC: begin
                  if (last_pair_s) begin
                     result_q <= acc_sum_s;
                     done_q   <= 1'b1;
                     state_q  <= ST_FINISH;
                  end else begin
                     i_q         <= i_d;
                     j_q         <= j_d;
                     mul_a_q     <= limb_sel(a_q, i_d);
                     mul_b_q     <= limb_sel(b_q, j_d);
                     mul_start_q <= 1'b1;
                     state_q     <= ST_ISSUE;
                  end
               end
               ST_FINISH: begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
               default: begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.result    = result_q;
   assign bus.mul_start = mul_start_q;
   assign bus.mul_a     = mul_a_q;
   assign bus.mul_b     = mul_b_q;

endmodule

// File: tb/tb_mul_limb_scheduler.sv
// Bench for mul_limb_scheduler: vector table plus hand-written abort, timeout
// and reset sequences, checked against plain wide-integer arithmetic.
module tb_mul_limb_scheduler;
   import mul_sched_pkg::*;

   localparam int TMO = 15;

   typedef struct {
      logic [OP_W-1:0]  a;
      logic [OP_W-1:0]  b;
      int               n;
      logic [RES_W-1:0] exp_res;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   mul_limb_scheduler_if bus ();

   mul_limb_scheduler #(.TIMEOUT(TMO)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Multiplier model: returns a*b N cycles after each mul_start (N=0: never).
   int                lat_n       = 1;
   logic              inj_en      = 1'b0;
   int                m_cnt       = 0;
   int                m_age       = 1000;
   logic              m_done      = 1'b0;
   logic [PROD_W-1:0] m_prod      = '0;
   logic [LIMB_W-1:0] held_a      = '0;
   logic [LIMB_W-1:0] held_b      = '0;
   int                start_total = 0;
   int                done_total  = 0;
   int                err_total   = 0;
   int                unstable    = 0;
   logic [PROD_W-1:0] issued_q[$];
   logic              inj_now;

   assign inj_now      = inj_en && (m_age == lat_n + 1);
   assign bus.mul_done = m_done | inj_now;
   assign bus.mul_p    = inj_now ? ~m_prod : m_prod;

   always @(negedge clk) begin
      if (rst) begin
         m_cnt  <= 0;
         m_age  <= 1000;
         m_done <= 1'b0;
      end else if (bus.mul_start) begin
         m_cnt       <= lat_n;
         m_age       <= 0;
         m_done      <= 1'b0;
         m_prod      <= {{LIMB_W{1'b0}}, bus.mul_a} * {{LIMB_W{1'b0}}, bus.mul_b};
         held_a      <= bus.mul_a;
         held_b      <= bus.mul_b;
         start_total <= start_total + 1;
         issued_q.push_back({bus.mul_a, bus.mul_b});
      end else begin
         m_age <= m_age + 1;
         if (m_cnt != 0) begin
            m_cnt  <= m_cnt - 1;
            m_done <= (m_cnt == 1);
            if ((bus.mul_a !== held_a) || (bus.mul_b !== held_b)) unstable <= unstable + 1;
         end else begin
            m_done <= 1'b0;
         end
      end
      if (bus.done) done_total <= done_total + 1;
      if (bus.err)  err_total  <= err_total + 1;
   end

   task automatic chk(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h", name,
                  act[RES_W-1 -: 64], act[127:0], exp[RES_W-1 -: 64], exp[127:0]);
      end
   endtask

   function automatic logic [OP_W-1:0] rand_op();
      logic [OP_W-1:0] v;
      for (int k = 0; k < OP_W / 32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [RES_W-1:0] golden(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
      return {{OP_W{1'b0}}, a} * {{OP_W{1'b0}}, b};
   endfunction

   // cycles counts clock edges with the accepting start edge as 1.
   task automatic run_op(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input int n,
                         input logic hold_start, output int cycles, output logic got_done,
                         output logic got_err, output logic busy_at_done);
      bus.op_a     = a;
      bus.op_b     = b;
      bus.start    = 1'b1;
      lat_n        = n;
      got_done     = 1'b0;
      got_err      = 1'b0;
      busy_at_done = 1'b0;
      @(posedge clk);
      cycles = 1;
      @(negedge clk);
      bus.start = hold_start;
      bus.op_a  = rand_op();
      bus.op_b  = rand_op();
      for (int k = 0; k < 600; k++) begin
         if (bus.done) begin
            got_done     = 1'b1;
            busy_at_done = bus.busy;
            break;
         end
         if (bus.err) begin
            got_err = 1'b1;
            break;
         end
         @(posedge clk);
         cycles++;
         @(negedge clk);
      end
      bus.start = 1'b0;
   endtask

   vec_t             vecs[7];
   logic [RES_W-1:0] last_exp;
   logic [OP_W-1:0]  ta, tb;
   int               cyc, base, qbase, mis, seen, dn, er;
   logic             gd, ge, bd;

   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.op_a  = '0;
      bus.op_b  = '0;
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy",      RES_W'(bus.busy),      RES_W'(0));
      chk("rst_done",      RES_W'(bus.done),      RES_W'(0));
      chk("rst_err",       RES_W'(bus.err),       RES_W'(0));
      chk("rst_mul_start", RES_W'(bus.mul_start), RES_W'(0));
      chk("rst_result",    bus.result,            RES_W'(0));
      chk("rst_mul_ab",    RES_W'({bus.mul_a, bus.mul_b}), RES_W'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", RES_W'(bus.busy), RES_W'(0));

      vecs[0] = '{a: OP_W'(3), b: OP_W'(5), n: 1, exp_res: RES_W'(15)};
      vecs[1] = '{a: {OP_W{1'b1}}, b: {OP_W{1'b1}}, n: 2,
                  exp_res: RES_W'(1) - (RES_W'(1) << (OP_W + 1))};
      vecs[2] = '{a: OP_W'(1) << 768, b: OP_W'(1) << 256, n: 7, exp_res: RES_W'(1) << 1024};
      for (int v = 3; v < 7; v++) begin
         ta = rand_op();
         tb = rand_op();
         vecs[v] = '{a: ta, b: tb, n: ((v == 6) ? TMO : int'($urandom_range(1, 6))),
                     exp_res: golden(ta, tb)};
      end

      for (int v = 0; v < 7; v++) begin
         base  = start_total;
         qbase = issued_q.size();
         run_op(vecs[v].a, vecs[v].b, vecs[v].n, 1'b0, cyc, gd, ge, bd);
         chk($sformatf("v%0d_done", v),      RES_W'(gd),  RES_W'(1));
         chk($sformatf("v%0d_latency", v),   RES_W'(cyc), RES_W'(16 * (vecs[v].n + 2) + 1));
         chk($sformatf("v%0d_result", v),    bus.result,  vecs[v].exp_res);
         chk($sformatf("v%0d_busy_done", v), RES_W'(bd),  RES_W'(1));
         @(negedge clk);
         chk($sformatf("v%0d_idle", v), RES_W'({bus.busy, bus.done}), RES_W'(0));
         chk($sformatf("v%0d_nstart", v), RES_W'(start_total - base), RES_W'(16));
         mis = 0;
         for (int k = 0; k < 16; k++) begin
            if (qbase + k >= issued_q.size()) mis++;
            else if (issued_q[qbase + k] !== {vecs[v].a[(k / 4) * LIMB_W +: LIMB_W],
                                               vecs[v].b[(k % 4) * LIMB_W +: LIMB_W]}) mis++;
         end
         chk($sformatf("v%0d_order", v), RES_W'(mis), RES_W'(0));
         last_exp = vecs[v].exp_res;
      end
      chk("operand_stable", RES_W'(unstable), RES_W'(0));

      // start held high throughout, plus a stray mul_done in every ACC cycle
      ta = rand_op();
      tb = rand_op();
      inj_en = 1'b1;
      run_op(ta, tb, 2, 1'b1, cyc, gd, ge, bd);
      inj_en = 1'b0;
      chk("ign_done",    RES_W'(gd),  RES_W'(1));
      chk("ign_latency", RES_W'(cyc), RES_W'(16 * 4 + 1));
      chk("ign_result",  bus.result,  golden(ta, tb));
      last_exp = golden(ta, tb);
      repeat (3) @(negedge clk);
      chk("ign_no_queue", RES_W'(bus.busy), RES_W'(0));

      // abort in the WAIT of the fifth pair
      dn = done_total;
      er = err_total;
      bus.op_a  = rand_op();
      bus.op_b  = rand_op();
      bus.start = 1'b1;
      lat_n     = 4;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      seen = 0;
      for (int k = 0; k < 200; k++) begin
         if (bus.mul_start) seen++;
         if (seen == 5) break;
         @(negedge clk);
      end
      chk("abort_reach", RES_W'(seen), RES_W'(5));
      @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("abort_busy",   RES_W'(bus.busy), RES_W'(0));
      chk("abort_result", bus.result,       last_exp);
      repeat (10) @(negedge clk);
      chk("abort_no_done", RES_W'(done_total - dn), RES_W'(0));
      chk("abort_no_err",  RES_W'(err_total - er),  RES_W'(0));
      chk("abort_idle",    RES_W'(bus.busy),        RES_W'(0));
      ta = rand_op();
      tb = rand_op();
      run_op(ta, tb, 1, 1'b0, cyc, gd, ge, bd);
      chk("post_abort_done",   RES_W'(gd), RES_W'(1));
      chk("post_abort_result", bus.result, golden(ta, tb));
      last_exp = golden(ta, tb);
      @(negedge clk);

      // multiplier never answers
      dn = done_total;
      run_op(rand_op(), rand_op(), 0, 1'b0, cyc, gd, ge, bd);
      chk("tmo_err",       RES_W'(ge),      RES_W'(1));
      chk("tmo_latency",   RES_W'(cyc - 1), RES_W'(TMO + 1));
      @(negedge clk);
      chk("tmo_err_pulse", RES_W'(bus.err),  RES_W'(0));
      chk("tmo_idle",      RES_W'(bus.busy), RES_W'(0));
      chk("tmo_result",    bus.result,       last_exp);
      chk("tmo_no_done",   RES_W'(done_total - dn), RES_W'(0));

      // asynchronous reset in the ACC of the third pair
      bus.op_a  = rand_op();
      bus.op_b  = rand_op();
      bus.start = 1'b1;
      lat_n     = 1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      seen = 0;
      for (int k = 0; k < 100; k++) begin
         if (bus.mul_start) seen++;
         if (seen == 3) break;
         @(negedge clk);
      end
      chk("rst_reach", RES_W'(seen), RES_W'(3));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("arst_busy",   RES_W'({bus.busy, bus.done, bus.err, bus.mul_start}), RES_W'(0));
      chk("arst_result", bus.result, RES_W'(0));
      chk("arst_mul_ab", RES_W'({bus.mul_a, bus.mul_b}), RES_W'(0));
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("arst_stays_idle", RES_W'(bus.busy), RES_W'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
